// File: rtl/fpu_wb_sched.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | fpu_wb_sched: FP writeback merge (add/mul pipe + div/sqrt) with scoreboard   |
// | Optional sticky-flag accumulation: FPU_FFLAGS_ACCUM_EN.  Rev 1.0            |
// +-----------------------------------------------------------------------------+
module fpu_wb_sched #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  issue_valid_i,
  input  logic                  issue_wr_i,
  input  logic [ADDR_WIDTH-1:0] issue_rd_addr_i,
  input  logic [ADDR_WIDTH-1:0] rs1_addr_i,
  input  logic [ADDR_WIDTH-1:0] rs2_addr_i,
  input  logic [ADDR_WIDTH-1:0] rs3_addr_i,
  output logic                  stall_o,
  input  logic                  pipe_valid_i,
  input  logic [ADDR_WIDTH-1:0] pipe_rd_addr_i,
  input  logic [DATA_WIDTH-1:0] pipe_data_i,
  input  logic [4:0]            pipe_flags_i,
  output logic                  pipe_stall_o,
  input  logic                  div_valid_i,
  output logic                  div_ready_o,
  input  logic [ADDR_WIDTH-1:0] div_rd_addr_i,
  input  logic [DATA_WIDTH-1:0] div_data_i,
  input  logic [4:0]            div_flags_i,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_wren_o,
  input  logic                  clear_flags_i,
  output logic [4:0]            fflags_o
);

  localparam int c_num_regs = 2 ** ADDR_WIDTH;
  localparam int c_cnt_w    = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(STARVE_LIMIT - 1);

  logic [c_num_regs-1:0] busy_q, busy_d;
  logic                  hold_valid_q, hold_valid_d;
  logic [ADDR_WIDTH-1:0] hold_addr_q, hold_addr_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic [c_cnt_w-1:0]    starve_cnt_q, starve_cnt_d;
  logic                  pipe_stall_q, pipe_stall_d;
  logic                  rd_wren_q, rd_wren_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  w_div_acc;
  logic                  w_issue_acc;

  assign stall_o = issue_valid_i & (busy_q[rs1_addr_i] | busy_q[rs2_addr_i] |
                                    busy_q[rs3_addr_i] |
                                    (issue_wr_i & busy_q[issue_rd_addr_i]));
  assign w_issue_acc = issue_valid_i & ~stall_o;
  assign div_ready_o = ~hold_valid_q;
  assign w_div_acc   = div_valid_i & ~hold_valid_q;

  // Pipe results cannot be back-pressured, so they always win; div parks in hold.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_addr_d  = hold_addr_q;
    hold_data_d  = hold_data_q;
    rd_wren_d    = 1'b0;
    rd_addr_d    = rd_addr_q;
    rd_data_d    = rd_data_q;
    if (pipe_valid_i) begin
      rd_wren_d = 1'b1;
      rd_addr_d = pipe_rd_addr_i;
      rd_data_d = pipe_data_i;
      if (w_div_acc) begin
        hold_valid_d = 1'b1;
        hold_addr_d  = div_rd_addr_i;
        hold_data_d  = div_data_i;
      end
    end else if (hold_valid_q) begin
      rd_wren_d    = 1'b1;
      rd_addr_d    = hold_addr_q;
      rd_data_d    = hold_data_q;
      hold_valid_d = 1'b0;
    end else if (w_div_acc) begin
      rd_wren_d = 1'b1;
      rd_addr_d = div_rd_addr_i;
      rd_data_d = div_data_i;
    end
  end

  // Counter saturates so a misbehaving upstream keeps seeing pipe_stall_o.
  always_comb begin
    starve_cnt_d = '0;
    pipe_stall_d = 1'b0;
    if (hold_valid_q && pipe_valid_i) begin
      pipe_stall_d = (starve_cnt_q == c_cnt_max);
      starve_cnt_d = (starve_cnt_q == c_cnt_max) ? starve_cnt_q : starve_cnt_q + 1'b1;
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (rd_wren_q) busy_d[rd_addr_q] = 1'b0;
    if (w_issue_acc && issue_wr_i && (issue_rd_addr_i != '0)) busy_d[issue_rd_addr_i] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q       <= '0;
      hold_valid_q <= 1'b0;
      hold_addr_q  <= '0;
      hold_data_q  <= '0;
      starve_cnt_q <= '0;
      pipe_stall_q <= 1'b0;
      rd_wren_q    <= 1'b0;
      rd_addr_q    <= '0;
      rd_data_q    <= '0;
    end else begin
      busy_q       <= busy_d;
      hold_valid_q <= hold_valid_d;
      hold_addr_q  <= hold_addr_d;
      hold_data_q  <= hold_data_d;
      starve_cnt_q <= starve_cnt_d;
      pipe_stall_q <= pipe_stall_d;
      rd_wren_q    <= rd_wren_d;
      rd_addr_q    <= rd_addr_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign pipe_stall_o = pipe_stall_q;
  assign rd_wren_o    = rd_wren_q;
  assign rd_addr_o    = rd_addr_q;
  assign rd_data_o    = rd_data_q;

`ifdef FPU_FFLAGS_ACCUM_EN
  logic [4:0] hold_flags_q, hold_flags_d;
  logic [4:0] fflags_q, fflags_d;
  logic [4:0] w_sel_flags;

  // Mirrors the data select so flags land on the same edge as their result.
  always_comb begin
    hold_flags_d = hold_flags_q;
    w_sel_flags  = 5'b0;
    if (pipe_valid_i) begin
      w_sel_flags = pipe_flags_i;
      if (w_div_acc) hold_flags_d = div_flags_i;
    end else if (hold_valid_q) begin
      w_sel_flags = hold_flags_q;
    end else if (w_div_acc) begin
      w_sel_flags = div_flags_i;
    end
    fflags_d = (clear_flags_i ? 5'b0 : fflags_q) | w_sel_flags;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_flags_q <= 5'b0;
      fflags_q     <= 5'b0;
    end else begin
      hold_flags_q <= hold_flags_d;
      fflags_q     <= fflags_d;
    end
  end

  assign fflags_o = fflags_q;
`else
  logic w_unused_flags;
  assign w_unused_flags = ^{pipe_flags_i, div_flags_i, clear_flags_i};
  assign fflags_o       = 5'b0;
`endif

`ifndef SYNTHESIS
  ap_no_pipe_when_stalled: assert property (@(posedge clk_i) disable iff (rst_i)
    !(pipe_valid_i && pipe_stall_q));
  ap_wb_to_busy_reg: assert property (@(posedge clk_i) disable iff (rst_i)
    !(rd_wren_q && (rd_addr_q != '0) && !busy_q[rd_addr_q]));
`endif

endmodule
`default_nettype wire

// File: tb/tb_fpu_wb_sched.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_fpu_wb_sched: directed self-checking bench for fpu_wb_sched. Rev 1.0      |
// +-----------------------------------------------------------------------------+
module tb_fpu_wb_sched;

`ifdef FPU_FFLAGS_ACCUM_EN
  localparam bit c_acc = 1'b1;
`else
  localparam bit c_acc = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        issue_valid_i = 1'b0;
  logic        issue_wr_i = 1'b0;
  logic [4:0]  issue_rd_addr_i = '0;
  logic [4:0]  rs1_addr_i = '0;
  logic [4:0]  rs2_addr_i = '0;
  logic [4:0]  rs3_addr_i = '0;
  logic        stall_o;
  logic        pipe_valid_i = 1'b0;
  logic [4:0]  pipe_rd_addr_i = '0;
  logic [31:0] pipe_data_i = '0;
  logic [4:0]  pipe_flags_i = '0;
  logic        pipe_stall_o;
  logic        div_valid_i = 1'b0;
  logic        div_ready_o;
  logic [4:0]  div_rd_addr_i = '0;
  logic [31:0] div_data_i = '0;
  logic [4:0]  div_flags_i = '0;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
  logic        rd_wren_o;
  logic        clear_flags_i = 1'b0;
  logic [4:0]  fflags_o;

  int n_checks = 0;
  int n_pass   = 0;

  fpu_wb_sched #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .STARVE_LIMIT(4)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_wr_i(issue_wr_i),
    .issue_rd_addr_i(issue_rd_addr_i), .rs1_addr_i(rs1_addr_i),
    .rs2_addr_i(rs2_addr_i), .rs3_addr_i(rs3_addr_i), .stall_o(stall_o),
    .pipe_valid_i(pipe_valid_i), .pipe_rd_addr_i(pipe_rd_addr_i),
    .pipe_data_i(pipe_data_i), .pipe_flags_i(pipe_flags_i), .pipe_stall_o(pipe_stall_o),
    .div_valid_i(div_valid_i), .div_ready_o(div_ready_o),
    .div_rd_addr_i(div_rd_addr_i), .div_data_i(div_data_i), .div_flags_i(div_flags_i),
    .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o), .rd_wren_o(rd_wren_o),
    .clear_flags_i(clear_flags_i), .fflags_o(fflags_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One accepted writing issue per cycle; all sources are f0 so it never stalls.
  task automatic issue_rd(input logic [4:0] rd);
    issue_valid_i = 1'b1; issue_wr_i = 1'b1; issue_rd_addr_i = rd;
    rs1_addr_i = '0; rs2_addr_i = '0; rs3_addr_i = '0;
    tick();
    issue_valid_i = 1'b0; issue_wr_i = 1'b0; issue_rd_addr_i = '0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check("rst_wren",  64'(rd_wren_o), 64'd0);
    check("rst_addr",  64'(rd_addr_o), 64'd0);
    check("rst_data",  64'(rd_data_o), 64'd0);
    check("rst_pstall", 64'(pipe_stall_o), 64'd0);
    check("rst_dready", 64'(div_ready_o), 64'd1);
    check("rst_fflags", 64'(fflags_o), 64'd0);
    rst_i = 1'b0;
    tick();

    // RAW hazard on f3 held until the cycle after the writeback
    issue_valid_i = 1'b1; issue_wr_i = 1'b1; issue_rd_addr_i = 5'd3;
    #1 check("raw_first_issue", 64'(stall_o), 64'd0);
    tick();
    issue_wr_i = 1'b0; issue_rd_addr_i = '0; rs1_addr_i = 5'd3;
    #1 check("raw_stall_a", 64'(stall_o), 64'd1);
    tick();
    check("raw_stall_b", 64'(stall_o), 64'd1);
    pipe_valid_i = 1'b1; pipe_rd_addr_i = 5'd3; pipe_data_i = 32'h3F80_0000;
    tick();
    pipe_valid_i = 1'b0;
    check("raw_wb_wren", 64'(rd_wren_o), 64'd1);
    check("raw_wb_addr", 64'(rd_addr_o), 64'd3);
    check("raw_wb_data", 64'(rd_data_o), 64'h3F80_0000);
    check("raw_stall_at_wb", 64'(stall_o), 64'd1);
    tick();
    check("raw_unstall", 64'(stall_o), 64'd0);
    check("raw_wren_off", 64'(rd_wren_o), 64'd0);
    issue_valid_i = 1'b0; rs1_addr_i = '0;
    tick();

    // f0 is never marked busy
    issue_valid_i = 1'b1; issue_wr_i = 1'b1; issue_rd_addr_i = 5'd0;
    tick();
    issue_wr_i = 1'b1; issue_rd_addr_i = 5'd0; rs1_addr_i = 5'd0;
    #1 check("f0_no_stall", 64'(stall_o), 64'd0);
    issue_valid_i = 1'b0; issue_wr_i = 1'b0;
    tick();

    // Same-cycle pipe + div collision, then bypass, plus flag accumulation
    issue_rd(5'd4); issue_rd(5'd5); issue_rd(5'd6);
    check("col_ready_pre", 64'(div_ready_o), 64'd1);
    pipe_valid_i = 1'b1; pipe_rd_addr_i = 5'd4; pipe_data_i = 32'h4040_0000; pipe_flags_i = 5'b00001;
    div_valid_i  = 1'b1; div_rd_addr_i  = 5'd5; div_data_i  = 32'h4080_0000; div_flags_i  = 5'b10000;
    tick();
    pipe_valid_i = 1'b0; div_valid_i = 1'b0; pipe_flags_i = '0; div_flags_i = '0;
    check("col_f4_addr", 64'(rd_addr_o), 64'd4);
    check("col_f4_data", 64'(rd_data_o), 64'h4040_0000);
    check("col_ready_low", 64'(div_ready_o), 64'd0);
    check("col_flags_a", 64'(fflags_o), c_acc ? 64'b00001 : 64'd0);
    tick();
    check("col_f5_wren", 64'(rd_wren_o), 64'd1);
    check("col_f5_addr", 64'(rd_addr_o), 64'd5);
    check("col_f5_data", 64'(rd_data_o), 64'h4080_0000);
    check("col_ready_back", 64'(div_ready_o), 64'd1);
    check("col_flags_b", 64'(fflags_o), c_acc ? 64'b10001 : 64'd0);
    div_valid_i = 1'b1; div_rd_addr_i = 5'd6; div_data_i = 32'h40A0_0000; div_flags_i = 5'b00100;
    clear_flags_i = 1'b1;
    tick();
    div_valid_i = 1'b0; div_flags_i = '0;
    check("byp_addr", 64'(rd_addr_o), 64'd6);
    check("byp_data", 64'(rd_data_o), 64'h40A0_0000);
    check("clr_new_flags", 64'(fflags_o), c_acc ? 64'b00100 : 64'd0);
    tick();
    clear_flags_i = 1'b0;
    check("idle_wren", 64'(rd_wren_o), 64'd0);
    check("idle_addr_kept", 64'(rd_addr_o), 64'd6);
    check("idle_data_kept", 64'(rd_data_o), 64'h40A0_0000);
    check("clr_flags", 64'(fflags_o), 64'd0);

    // Div starvation: pipe streams f10..f14 while f9 sits in hold
    for (int r = 9; r <= 14; r++) issue_rd(5'(r));
    pipe_valid_i = 1'b1; pipe_rd_addr_i = 5'd10; pipe_data_i = 32'h0000_000A;
    div_valid_i  = 1'b1; div_rd_addr_i  = 5'd9;  div_data_i  = 32'h0000_0009;
    for (int k = 1; k <= 5; k++) begin
      tick();
      div_valid_i = 1'b0;
      check($sformatf("starve_pstall_%0d", k), 64'(pipe_stall_o), (k == 5) ? 64'd1 : 64'd0);
      check($sformatf("starve_addr_%0d", k), 64'(rd_addr_o), 64'(9 + k));
      pipe_valid_i   = (k < 5);
      pipe_rd_addr_i = 5'(10 + k);
      pipe_data_i    = 32'(10 + k);
    end
    tick();
    pipe_valid_i = 1'b0;
    check("starve_div_addr", 64'(rd_addr_o), 64'd9);
    check("starve_div_data", 64'(rd_data_o), 64'h0000_0009);
    check("starve_pstall_drop", 64'(pipe_stall_o), 64'd0);
    check("starve_ready", 64'(div_ready_o), 64'd1);
    tick();

    // Async reset while hold is full and f7 is busy
    issue_rd(5'd7); issue_rd(5'd8);
    pipe_valid_i = 1'b1; pipe_rd_addr_i = 5'd8; pipe_data_i = 32'h0000_0008;
    div_valid_i  = 1'b1; div_rd_addr_i  = 5'd7; div_data_i  = 32'h0000_0007;
    tick();
    pipe_valid_i = 1'b0; div_valid_i = 1'b0;
    issue_valid_i = 1'b1; rs1_addr_i = 5'd7;
    #1 check("rst5_busy_pre", 64'(stall_o), 64'd1);
    check("rst5_hold_full", 64'(div_ready_o), 64'd0);
    rst_i = 1'b1;
    #1 check("rst5_ready", 64'(div_ready_o), 64'd1);
    check("rst5_busy_clr", 64'(stall_o), 64'd0);
    tick();
    rst_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("rst5_no_wb_%0d", k), 64'(rd_wren_o), 64'd0);
    end
    issue_valid_i = 1'b0; rs1_addr_i = '0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
